// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: registered one-hot grants, hmaster/hmastlock, fixed bursts never broken.
// Optional locked-transfer support is enabled by defining AHB_ARB_LOCK_EN.
module ahb_arbiter #(
    parameter int NUM_M     = 4,
    parameter int DEFAULT_M = 0
) (
    input  logic                       clk,
    input  logic                       hreset,
    input  logic [NUM_M-1:0]           hbusreq,
    input  logic [NUM_M-1:0]           hlock,
    input  logic [1:0]                 htrans,
    input  logic [2:0]                 hburst,
    input  logic                       hready,
    output logic [NUM_M-1:0]           hgrant,
    output logic [$clog2(NUM_M)-1:0]   hmaster,
    output logic                       hmastlock
);
    localparam int MW = $clog2(NUM_M);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_M);

    logic [0:0]       state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [3:0]       burst_len;
    logic [MW-1:0]    owner_reg, owner_next;
    logic [MW-1:0]    last_reg, last_next;
    logic [MW-1:0]    winner;
    logic             any_req;
    logic             lock_hold;
    logic             arb_point;
    logic [NUM_M-1:0] grant_oh_next;
    logic [NUM_M-1:0] grant_oh_default;
    logic [NUM_M-1:0] hgrant_reg;
    logic [MW-1:0]    hmaster_reg;
    logic             hmastlock_reg;

    always_comb begin
        case (hburst)
            3'd2, 3'd3: burst_len = 4'd3;
            3'd4, 3'd5: burst_len = 4'd7;
            3'd6, 3'd7: burst_len = 4'd15;
            default:    burst_len = 4'd0;
        endcase
    end

    // Beats still owed by a fixed-length burst; frozen during wait states.
    always_comb begin
        cnt_next = cnt_reg;
        if (hready) begin
            case (htrans)
                TR_NONSEQ: cnt_next = burst_len;
                TR_SEQ:    cnt_next = (cnt_reg == 4'd0) ? 4'd0 : cnt_reg - 4'd1;
                TR_IDLE:   cnt_next = 4'd0;
                default:   cnt_next = cnt_reg;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ARB:   if (cnt_next != 4'd0) state_next = ST_BURST;
            ST_BURST: if (cnt_next == 4'd0) state_next = ST_ARB;
            default:  state_next = ST_ARB;
        endcase
    end

`ifdef AHB_ARB_LOCK_EN
    assign lock_hold = hlock[owner_reg];
`else
    logic unused_hlock;
    assign unused_hlock = ^hlock;
    assign lock_hold    = 1'b0;
`endif

    assign arb_point = hready && (htrans != TR_BUSY) && (cnt_next == 4'd0) && !lock_hold;
    assign any_req   = |hbusreq;

    // Rotating scan: first requester after the last winner, wrapping.
    always_comb begin
        logic          found;
        logic [MW-1:0] idx;
        winner = DEF_IDX;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = MW'((int'(last_reg) + k) % NUM_M);
            if (!found && hbusreq[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        owner_next = owner_reg;
        last_next  = last_reg;
        if (arb_point) begin
            if (any_req) begin
                owner_next = winner;
                if (winner != owner_reg) last_next = winner;
            end else begin
                owner_next = DEF_IDX;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : g_grant_dec
            assign grant_oh_next[gi]    = (owner_next == MW'(gi));
            assign grant_oh_default[gi] = (gi == DEFAULT_M);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (hreset) begin
            state_reg     <= ST_ARB;
            cnt_reg       <= 4'd0;
            owner_reg     <= DEF_IDX;
            last_reg      <= DEF_IDX;
            hgrant_reg    <= grant_oh_default;
            hmaster_reg   <= DEF_IDX;
            hmastlock_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            owner_reg  <= owner_next;
            last_reg   <= last_next;
            hgrant_reg <= grant_oh_next;
            // Address-phase ownership trails the grant by one accepted transfer.
            if (hready) begin
                hmaster_reg <= owner_reg;
`ifdef AHB_ARB_LOCK_EN
                hmastlock_reg <= hlock[owner_reg];
`else
                hmastlock_reg <= 1'b0;
`endif
            end
        end
    end

    assign hgrant    = hgrant_reg;
    assign hmaster   = hmaster_reg;
    assign hmastlock = hmastlock_reg;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter (NUM_M=4, DEFAULT_M=0): directed steps push expected outputs, a monitor compares.
module tb_ahb_arbiter;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2, SEQ = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0, WRAP16 = 3'd6, INCR4 = 3'd3, INCR8 = 3'd5;

    logic       clk = 1'b0;
    logic       hreset = 1'b1;
    logic [3:0] hbusreq = '0;
    logic [3:0] hlock = '0;
    logic [1:0] htrans = IDLE;
    logic [2:0] hburst = SINGLE;
    logic       hready = 1'b1;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    typedef struct {
        logic [3:0] g;
        logic [1:0] m;
        logic       l;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    ahb_arbiter #(.NUM_M(4), .DEFAULT_M(0)) dut (
        .clk(clk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
        .htrans(htrans), .hburst(hburst), .hready(hready),
        .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
    );

    always #5 clk = ~clk;

    // Monitor: after each edge, compare DUT outputs against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (hgrant === e.g && hmaster === e.m && hmastlock === e.l && $onehot(hgrant)) begin
                n_pass++;
                $display("ok   %-14s hgrant=%b hmaster=%0d hmastlock=%0d", e.name, hgrant, hmaster, hmastlock);
            end else begin
                $display("FAIL %-14s got hgrant=%b hmaster=%0d hmastlock=%0d, want hgrant=%b hmaster=%0d hmastlock=%0d",
                         e.name, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
            end
        end
    end

    task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] lck,
                        input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                        input logic [3:0] eg, input logic [1:0] em, input logic el,
                        input string name);
        exp_t e;
        @(negedge clk);
        hreset  = rst;
        hbusreq = req;
        hlock   = lck;
        htrans  = tr;
        hburst  = bu;
        hready  = rdy;
        e.g = eg; e.m = em; e.l = el; e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset and park
        step(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1, 4'b0001, 0, 0, "reset0");
        step(1, 4'b0000, 4'b0000, IDLE, SINGLE, 1, 4'b0001, 0, 0, "reset1");
        for (int i = 0; i < 10; i++)
            step(0, 4'b0000, 4'b0000, IDLE, SINGLE, 1, 4'b0001, 0, 0, "park");

        // Rotation with every master requesting SINGLE transfers
        step(0, 4'b1111, 4'b0000, NSEQ, SINGLE, 1, 4'b0010, 0, 0, "rot1");
        step(0, 4'b1111, 4'b0000, NSEQ, SINGLE, 1, 4'b0100, 1, 0, "rot2");
        step(0, 4'b1111, 4'b0000, NSEQ, SINGLE, 1, 4'b1000, 2, 0, "rot3");
        step(0, 4'b1111, 4'b0000, NSEQ, SINGLE, 1, 4'b0001, 3, 0, "rot0");
        step(0, 4'b1111, 4'b0000, NSEQ, SINGLE, 1, 4'b0010, 0, 0, "rot1b");

        // Master 2 takes the bus, runs INCR8 while master 3 waits; 3 wait states mid-burst
        step(0, 4'b0100, 4'b0000, IDLE, SINGLE, 1, 4'b0100, 1, 0, "m2_grant");
        step(0, 4'b1100, 4'b0000, NSEQ, INCR8,  1, 4'b0100, 2, 0, "incr8_ns");
        step(0, 4'b1100, 4'b0000, SEQ,  INCR8,  1, 4'b0100, 2, 0, "incr8_s1");
        step(0, 4'b1100, 4'b0000, SEQ,  INCR8,  1, 4'b0100, 2, 0, "incr8_s2");
        step(0, 4'b1100, 4'b0000, SEQ,  INCR8,  1, 4'b0100, 2, 0, "incr8_s3");
        for (int i = 0; i < 3; i++)
            step(0, 4'b1100, 4'b0000, SEQ, INCR8, 0, 4'b0100, 2, 0, "incr8_wait");
        step(0, 4'b1100, 4'b0000, SEQ,  INCR8,  1, 4'b0100, 2, 0, "incr8_s4");
        step(0, 4'b1100, 4'b0000, SEQ,  INCR8,  1, 4'b0100, 2, 0, "incr8_s5");
        step(0, 4'b1100, 4'b0000, SEQ,  INCR8,  1, 4'b0100, 2, 0, "incr8_s6");
        step(0, 4'b1100, 4'b0000, SEQ,  INCR8,  1, 4'b1000, 2, 0, "incr8_end");
        step(0, 4'b1000, 4'b0000, NSEQ, SINGLE, 1, 4'b1000, 3, 0, "m3_keeps");

        // Early termination of WRAP16 by master 1, master 0 waiting
        step(0, 4'b0010, 4'b0000, IDLE, SINGLE, 1, 4'b0010, 3, 0, "m1_grant");
        step(0, 4'b0011, 4'b0000, NSEQ, WRAP16, 1, 4'b0010, 1, 0, "wrap16_ns");
        for (int i = 0; i < 4; i++)
            step(0, 4'b0011, 4'b0000, SEQ, WRAP16, 1, 4'b0010, 1, 0, "wrap16_seq");
        step(0, 4'b0011, 4'b0000, IDLE, WRAP16, 1, 4'b0001, 1, 0, "wrap16_idle");
        // A stray SEQ with a cleared counter is an arbitration point
        step(0, 4'b0010, 4'b0000, SEQ,  SINGLE, 1, 4'b0010, 0, 0, "cnt_cleared");

        // Locked transfers by master 1 while master 2 requests
`ifdef AHB_ARB_LOCK_EN
        step(0, 4'b0110, 4'b0010, NSEQ, SINGLE, 1, 4'b0010, 1, 1, "lock_t1");
        step(0, 4'b0110, 4'b0010, NSEQ, SINGLE, 1, 4'b0010, 1, 1, "lock_t2");
        step(0, 4'b0110, 4'b0000, NSEQ, SINGLE, 1, 4'b0100, 1, 0, "lock_release");
`else
        step(0, 4'b0110, 4'b0010, NSEQ, SINGLE, 1, 4'b0100, 1, 0, "nolock_t1");
        step(0, 4'b0110, 4'b0010, NSEQ, SINGLE, 1, 4'b0010, 2, 0, "nolock_t2");
        step(0, 4'b0110, 4'b0000, NSEQ, SINGLE, 1, 4'b0100, 1, 0, "nolock_t3");
`endif

        // Reset during beat 3 of INCR4, with hready low on the reset edge
        step(0, 4'b0110, 4'b0000, NSEQ, INCR4, 1, 4'b0100, 2, 0, "incr4_ns");
        step(0, 4'b0110, 4'b0000, SEQ,  INCR4, 1, 4'b0100, 2, 0, "incr4_s1");
        step(1, 4'b0110, 4'b0000, SEQ,  INCR4, 0, 4'b0001, 0, 0, "reset_mid");
        // Pointer is back at 0, so master 1 beats master 2
        step(0, 4'b0110, 4'b0000, IDLE, SINGLE, 1, 4'b0010, 0, 0, "post_reset");

        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
